life_step: RTL and testbench
============================

LIFE_STEP -- requirements
Module: life_step

Interface
REQ-001 GRID_W, 80, grid width in cells; GRID_H, 60, grid height in cells.
REQ-002 aclk  in  1  single clock, all state on rising edge.
REQ-003 aresetn  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  request one generation update; sampled only in IDLE.
REQ-005 rd_addr  out  13  cell index (x + y*GRID_W) read from current bank.
REQ-006 rd_data  in  1  cell state, valid one cycle after rd_addr.
REQ-007 wr_en  out  1  write strobe to next bank.
REQ-008 wr_addr  out  13  cell index being written.
REQ-009 wr_data  out  1  next-generation state.
REQ-010 bank  out  1  bank holding the committed generation; the display read path uses it.
REQ-011 busy  out  1  high from the first READ cycle through the last WRITE.
REQ-012 done  out  1  one-cycle pulse at generation commit.
REQ-013 gen_count  out  16  committed generations, wraps at 65535->0.

Function
REQ-014 The FSM SHALL have three states: IDLE, READ, WRITE.
REQ-015 IDLE with start=1 SHALL go to READ at cell (0,0), busy=1; start is ignored in other states.
REQ-016 READ SHALL run phases k=0..9 per cell: for k=0..8 it issues neighbourhood addresses in row-major order (dy=-1..+1, dx=-1..+1), and k=4 is the cell itself.
REQ-017 Data returned for phase k SHALL be accumulated at phase k+1: neighbour count is 4 bits, 0..8, and self excludes it.
REQ-018 Neighbour coordinates SHALL wrap toroidally: x=-1 is 79, x=80 is 0, y=-1 is 59, y=60 is 0.
REQ-019 WRITE SHALL last one cycle per cell: wr_en=1, wr_addr=cell index, wr_data=(n==3)|(self&n==2).
REQ-020 After WRITE, x SHALL increment; at x=79 it SHALL go to x=0, y+1; after (79,59) the FSM goes to IDLE.
REQ-021 Each cell SHALL take exactly 11 cycles (10 READ + 1 WRITE); a generation takes 52800 cycles.
REQ-022 On the cycle after the write of (79,59): done=1, bank toggles, gen_count increments, busy=0.
REQ-023 Outside WRITE, wr_en SHALL be 0; rd_addr is don't-care outside READ phases 0..8.
REQ-024 start asserted on the done cycle SHALL be accepted (the FSM is in IDLE), so generations can run back to back.

Reset
REQ-025 aresetn=0 SHALL force IDLE, x=y=0, count=0, wr_en=0, busy=0, done=0, bank=0, gen_count=0, rd_addr=0, wr_addr=0, wr_data=0.
REQ-026 Reset mid-generation SHALL abandon the update with no further writes; bank stays 0, so the partially written bank is never committed.
REQ-027 The first start after reset release SHALL be honoured on the first rising edge with aresetn=1.

Structure
REQ-028 GRID_W, GRID_H, the 13-bit cell-index width, the cell-index function and the FSM state encoding SHALL live in a shared package, also used by the display-side memory.
REQ-029 One sub-module, life_rule, SHALL be combinational: inputs self and the 4-bit count, output is the next state.
REQ-030 The two cell-state banks SHALL be external to life_step, in the memory wrapper.

Verification
REQ-031 Blinker: cells (10,10),(11,10),(12,10) live, start -> after done, (11,9),(11,10),(11,11) live, others dead; a second start restores the original pattern.
REQ-032 Block still life: (0,0),(1,0),(0,1),(1,1) live -> unchanged after 3 generations; gen_count=3, bank=1.
REQ-033 Toroidal wrap: cells (79,0),(0,0),(1,0) live -> (0,59),(0,0),(0,1) live after one generation.
REQ-034 Timing: start pulse -> busy on the next edge, first wr_en exactly 11 cycles later, done exactly 52800 cycles after start sampled, start held during busy has no effect.
REQ-035 Reset at cycle 20000 of a generation -> wr_en=0 within the same cycle, bank=0, gen_count=0, and the next start runs a full 52800-cycle generation.

Source files
------------

// File: rtl/life_step_pkg.sv
// -----------------------------------------------------------------------------
// life_step_pkg
// Shared definitions for the Game of Life generation engine and the
// display-side cell memory: grid geometry, cell-index width, the helper that
// turns (x, y) into a linear cell index, and the engine FSM state encoding.
// No ports; imported with "import life_step_pkg::*;".
// -----------------------------------------------------------------------------
package life_step_pkg;

   // Grid geometry in cells.
   localparam int GRID_W = 80;
   localparam int GRID_H = 60;

   // Width of a linear cell index (x + y*GRID_W); 80*60 = 4800 fits in 13 bits.
   localparam int CELL_AW = 13;

   // Coordinate widths wide enough for GRID_W-1 and GRID_H-1.
   localparam int X_W = 7;
   localparam int Y_W = 6;

   localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

   // Per-cell read sequencing: phases 0..8 issue the 3x3 neighbourhood,
   // phase 9 only absorbs the data returned for phase 8.
   localparam logic [3:0] PHASE_LAST = 4'd9;
   localparam logic [3:0] PHASE_ADDR_LAST = 4'd8;

   // Data for the centre cell (issued at phase 4) lands one phase later.
   localparam logic [3:0] PHASE_SELF_DATA = 4'd5;

   // Engine FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } life_state_e;

   // Linear cell index used by both the engine and the display memory.
   function automatic logic [CELL_AW-1:0] cell_index(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
      logic [CELL_AW-1:0] idx;
      idx = CELL_AW'(x) + (CELL_AW'(y) * CELL_AW'(GRID_W));
      return idx;
   endfunction

endpackage

// File: rtl/life_step_rule.sv
// -----------------------------------------------------------------------------
// life_rule
// Combinational Conway rule: a cell is alive in the next generation when it
// has exactly three live neighbours, or when it is alive now and has exactly
// two live neighbours.
// Ports:
//   self_state  in   current state of the cell
//   n_count     in   number of live neighbours (0..8, self excluded)
//   next_state  out  state of the cell in the next generation
// -----------------------------------------------------------------------------
module life_rule (
   input  logic       self_state,
   input  logic [3:0] n_count,
   output logic       next_state
);

   // Birth on three neighbours, survival on two or three.
   assign next_state = (n_count == 4'd3) || (self_state && (n_count == 4'd2));

endmodule

// File: rtl/life_step.sv
// -----------------------------------------------------------------------------
// life_step
// Computes one Game of Life generation over a toroidal GRID_W x GRID_H grid.
// The engine reads the committed bank through a one-cycle-latency read port,
// walks every cell in raster order (10 read cycles + 1 write cycle per cell)
// and writes the next generation into the other bank. When the last cell is
// written the engine commits by toggling 'bank' and pulsing 'done'.
// Ports:
//   aclk       in   clock, all state updates on the rising edge
//   aresetn    in   asynchronous active-low reset
//   start      in   request one generation (only looked at while idle)
//   rd_addr    out  cell index read from the committed bank
//   rd_data    in   cell state, valid the cycle after rd_addr
//   wr_en      out  write strobe into the non-committed bank
//   wr_addr    out  cell index being written
//   wr_data    out  next-generation state of that cell
//   bank       out  bank holding the committed generation
//   busy       out  high while a generation is in progress
//   done       out  one-cycle pulse when a generation is committed
//   gen_count  out  number of committed generations (wraps)
// -----------------------------------------------------------------------------
module life_step
   import life_step_pkg::*;
(
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               start,
   output logic [CELL_AW-1:0] rd_addr,
   input  logic               rd_data,
   output logic               wr_en,
   output logic [CELL_AW-1:0] wr_addr,
   output logic               wr_data,
   output logic               bank,
   output logic               busy,
   output logic               done,
   output logic [15:0]        gen_count
);

   life_state_e state_q, state_d;

   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic [3:0]     phase_q, phase_d;
   logic [3:0]     count_q, count_d;
   logic           self_q, self_d;
   logic           bank_q, bank_d;
   logic [15:0]    gen_count_q, gen_count_d;
   logic           done_q, done_d;

   logic [X_W-1:0] x_minus, x_plus, nb_x;
   logic [Y_W-1:0] y_minus, y_plus, nb_y;
   logic           last_cell;
   logic           rule_next;

   life_rule u_rule (
      .self_state (self_q),
      .n_count    (count_q),
      .next_state (rule_next)
   );

   assign last_cell = (x_q == X_LAST) && (y_q == Y_LAST);

   // FSM state register; reset drops any generation in flight back to idle.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start is only honoured from idle, each cell spends
   // phases 0..9 reading and one cycle writing, and the write of the last
   // cell returns the engine to idle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_READ;
            end
         end
         ST_READ: begin
            if (phase_q == PHASE_LAST) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            if (last_cell) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_READ;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Toroidal neighbour coordinates, then selection of the neighbour for the
   // current read phase in row-major order (phase 4 is the cell itself).
   always_comb begin
      x_minus = (x_q == '0) ? X_LAST : x_q - 1'b1;
      x_plus  = (x_q == X_LAST) ? '0 : x_q + 1'b1;
      y_minus = (y_q == '0) ? Y_LAST : y_q - 1'b1;
      y_plus  = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      nb_x = x_q;
      nb_y = y_q;
      case (phase_q)
         4'd0: begin nb_x = x_minus; nb_y = y_minus; end
         4'd1: begin nb_x = x_q;     nb_y = y_minus; end
         4'd2: begin nb_x = x_plus;  nb_y = y_minus; end
         4'd3: begin nb_x = x_minus; nb_y = y_q;     end
         4'd4: begin nb_x = x_q;     nb_y = y_q;     end
         4'd5: begin nb_x = x_plus;  nb_y = y_q;     end
         4'd6: begin nb_x = x_minus; nb_y = y_plus;  end
         4'd7: begin nb_x = x_q;     nb_y = y_plus;  end
         4'd8: begin nb_x = x_plus;  nb_y = y_plus;  end
         default: begin nb_x = x_q;  nb_y = y_q;     end
      endcase
   end

   // Datapath next values. Read data arrives one phase after its address, so
   // phase p absorbs the cell issued at phase p-1: phase 5 captures the cell
   // itself and every other phase from 1 to 9 adds to the neighbour count.
   // The write of the final cell commits the generation.
   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      phase_d     = phase_q;
      count_d     = count_q;
      self_d      = self_q;
      bank_d      = bank_q;
      gen_count_d = gen_count_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               x_d     = '0;
               y_d     = '0;
               phase_d = '0;
               count_d = '0;
               self_d  = 1'b0;
            end
         end
         ST_READ: begin
            if (phase_q == 4'd0) begin
               count_d = '0;
               self_d  = 1'b0;
            end else if (phase_q == PHASE_SELF_DATA) begin
               self_d = rd_data;
            end else begin
               count_d = count_q + {3'b000, rd_data};
            end
            if (phase_q == PHASE_LAST) begin
               phase_d = '0;
            end else begin
               phase_d = phase_q + 4'd1;
            end
         end
         ST_WRITE: begin
            phase_d = '0;
            if (x_q == X_LAST) begin
               x_d = '0;
               if (y_q == Y_LAST) begin
                  y_d         = '0;
                  done_d      = 1'b1;
                  bank_d      = ~bank_q;
                  gen_count_d = gen_count_q + 16'd1;
               end else begin
                  y_d = y_q + 1'b1;
               end
            end else begin
               x_d = x_q + 1'b1;
            end
         end
         default: begin
            phase_d = '0;
         end
      endcase
   end

   // Datapath registers; bank and gen_count only move on a full commit, so a
   // reset mid-generation leaves the half-written bank uncommitted.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         x_q         <= '0;
         y_q         <= '0;
         phase_q     <= '0;
         count_q     <= '0;
         self_q      <= 1'b0;
         bank_q      <= 1'b0;
         gen_count_q <= '0;
         done_q      <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         phase_q     <= phase_d;
         count_q     <= count_d;
         self_q      <= self_d;
         bank_q      <= bank_d;
         gen_count_q <= gen_count_d;
         done_q      <= done_d;
      end
   end

   // Outputs decoded from the current state; addresses and write data are
   // held at zero whenever they are not meaningful.
   always_comb begin
      busy    = (state_q != ST_IDLE);
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = 1'b0;
      rd_addr = '0;
      case (state_q)
         ST_READ: begin
            if (phase_q <= PHASE_ADDR_LAST) begin
               rd_addr = cell_index(nb_x, nb_y);
            end
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            wr_addr = cell_index(x_q, y_q);
            wr_data = rule_next;
         end
         default: begin
            wr_en = 1'b0;
         end
      endcase
   end

   assign bank      = bank_q;
   assign done      = done_q;
   assign gen_count = gen_count_q;

endmodule

// File: tb/tb_life_step.sv
// -----------------------------------------------------------------------------
// tb_life_step
// Directed bench for life_step. A two-bank cell memory with one-cycle read
// latency sits around the engine. One grid holds three independent patterns
// (a blinker, a block and a blinker straddling the x wrap), so a single
// generation exercises oscillation, still life and toroidal wrap together.
// A generation is first interrupted by reset, then a full one is run with
// start held high throughout.
// -----------------------------------------------------------------------------
module tb_life_step;
   import life_step_pkg::*;

   logic               aclk = 1'b0;
   logic               aresetn;
   logic               start;
   logic [CELL_AW-1:0] rd_addr;
   logic               rd_data = 1'b0;
   logic               wr_en;
   logic [CELL_AW-1:0] wr_addr;
   logic               wr_data;
   logic               bank;
   logic               busy;
   logic               done;
   logic [15:0]        gen_count;

   // Memory load port driven by the stimulus.
   logic               loadEn;
   logic [CELL_AW-1:0] loadAddr;

   bit mem0 [0:GRID_W*GRID_H-1];
   bit mem1 [0:GRID_W*GRID_H-1];

   int nAsserts = 0;
   int nFails   = 0;

   life_step dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .start     (start),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .bank      (bank),
      .busy      (busy),
      .done      (done),
      .gen_count (gen_count)
   );

   // 10 ns clock.
   always #5 aclk = ~aclk;

   // Two-bank cell memory: reads come from the committed bank one cycle
   // after the address, writes go to the other bank.
   always @(posedge aclk) begin
      if (loadEn && (loadAddr < CELL_AW'(GRID_W*GRID_H))) begin
         mem0[loadAddr] <= 1'b1;
      end
      if (wr_en && (wr_addr < CELL_AW'(GRID_W*GRID_H))) begin
         if (bank) begin
            mem0[wr_addr] <= wr_data;
         end else begin
            mem1[wr_addr] <= wr_data;
         end
      end
      if (rd_addr < CELL_AW'(GRID_W*GRID_H)) begin
         rd_data <= bank ? mem1[rd_addr] : mem0[rd_addr];
      end else begin
         rd_data <= 1'b0;
      end
   end

   // Drives reset and start at a falling edge.
   task automatic applyStimulus(input logic rstN, input logic st);
      @(negedge aclk);
      aresetn = rstN;
      start   = st;
   endtask

   // One comparison point.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      // Initial live cells: wrap blinker, blinker, block.
      int initX [10] = '{79, 0, 1, 10, 11, 12, 40, 41, 40, 41};
      int initY [10] = '{ 0, 0, 0, 10, 10, 10, 30, 30, 31, 31};
      // Expected live cells after one generation.
      int expX  [10] = '{ 0, 0, 0, 11, 11, 11, 40, 41, 40, 41};
      int expY  [10] = '{59, 0, 1,  9, 10, 11, 30, 30, 31, 31};
      int cyc;
      int firstWr;
      int live;
      bit busyGap;

      aresetn  = 1'b0;
      start    = 1'b0;
      loadEn   = 1'b0;
      loadAddr = '0;
      $display("[TB] reset phase");
      repeat (3) @(negedge aclk);

      checkOutput("rst_busy",      32'(busy),      32'd0);
      checkOutput("rst_done",      32'(done),      32'd0);
      checkOutput("rst_wr_en",     32'(wr_en),     32'd0);
      checkOutput("rst_bank",      32'(bank),      32'd0);
      checkOutput("rst_gen_count", 32'(gen_count), 32'd0);
      checkOutput("rst_rd_addr",   32'(rd_addr),   32'd0);
      checkOutput("rst_wr_addr",   32'(wr_addr),   32'd0);
      checkOutput("rst_wr_data",   32'(wr_data),   32'd0);

      // Start during reset must not launch anything.
      applyStimulus(1'b0, 1'b1);
      @(negedge aclk);
      checkOutput("start_in_reset_busy", 32'(busy), 32'd0);

      // Preload the committed bank.
      for (int i = 0; i < 10; i++) begin
         @(negedge aclk);
         loadEn   = 1'b1;
         loadAddr = cell_index(X_W'(initX[i]), Y_W'(initY[i]));
      end
      @(negedge aclk);
      loadEn = 1'b0;

      // Release reset together with start: the first edge takes it (E0).
      $display("[TB] generation interrupted by reset");
      applyStimulus(1'b1, 1'b1);
      @(negedge aclk);
      start = 1'b0;
      checkOutput("busy_after_start", 32'(busy),    32'd1);
      // Phase 0 of cell (0,0) reads (79,59).
      checkOutput("rd_phase0_wrap",   32'(rd_addr), 32'd4799);
      @(negedge aclk);
      checkOutput("rd_phase1_wrap",   32'(rd_addr), 32'd4720);
      repeat (3) @(negedge aclk);
      checkOutput("rd_phase4_self",   32'(rd_addr), 32'd0);
      repeat (4) @(negedge aclk);
      checkOutput("rd_phase8",        32'(rd_addr), 32'd81);
      @(negedge aclk);
      checkOutput("wr_en_phase9",     32'(wr_en),   32'd0);
      @(negedge aclk);
      // After E10 the first write is on: cell (0,0) has 2 neighbours and lives.
      checkOutput("first_wr_en",      32'(wr_en),   32'd1);
      checkOutput("first_wr_addr",    32'(wr_addr), 32'd0);
      checkOutput("first_wr_data",    32'(wr_data), 32'd1);

      // After E20008 the engine is writing cell 1818 = (58,22).
      repeat (19998) @(negedge aclk);
      checkOutput("wr_en_before_reset",   32'(wr_en),   32'd1);
      checkOutput("wr_addr_before_reset", 32'(wr_addr), 32'd1818);
      #1 aresetn = 1'b0;
      #1;
      checkOutput("reset_mid_wr_en",     32'(wr_en),     32'd0);
      checkOutput("reset_mid_busy",      32'(busy),      32'd0);
      checkOutput("reset_mid_bank",      32'(bank),      32'd0);
      checkOutput("reset_mid_gen_count", 32'(gen_count), 32'd0);
      checkOutput("reset_mid_done",      32'(done),      32'd0);

      // Full generation with start held high the whole time.
      $display("[TB] full generation");
      applyStimulus(1'b1, 1'b1);
      @(posedge aclk);
      cyc     = 0;
      firstWr = -1;
      busyGap = 1'b0;
      while (cyc < 60000) begin
         @(posedge aclk);
         cyc++;
         @(negedge aclk);
         if (wr_en && (firstWr < 0)) firstWr = cyc;
         if (done) break;
         if (!busy) busyGap = 1'b1;
      end
      checkOutput("done_seen",      32'(done),      32'd1);
      checkOutput("done_latency",   32'(cyc),       32'd52800);
      checkOutput("first_wr_cycle", 32'(firstWr),   32'd10);
      checkOutput("busy_no_gap",    32'(busyGap),   32'd0);
      checkOutput("done_busy",      32'(busy),      32'd0);
      checkOutput("done_bank",      32'(bank),      32'd1);
      checkOutput("done_gen_count", 32'(gen_count), 32'd1);

      // New committed bank contents.
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("cell_%0d_%0d", expX[i], expY[i]),
                     32'(mem1[cell_index(X_W'(expX[i]), Y_W'(expY[i]))]), 32'd1);
      end
      live = 0;
      for (int i = 0; i < GRID_W*GRID_H; i++) begin
         live += int'(mem1[i]);
      end
      checkOutput("live_total", 32'(live), 32'd10);

      // Start still high on the done cycle launches the next generation.
      @(negedge aclk);
      checkOutput("b2b_busy", 32'(busy), 32'd1);
      checkOutput("b2b_done", 32'(done), 32'd0);
      checkOutput("b2b_bank", 32'(bank), 32'd1);
      start = 1'b0;
      repeat (2) @(negedge aclk);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
